pipe_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage core (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Merges stall requests into one per-stage stall vector that every pipeline register and pc_reg obeys:
  - ID requests single-cycle stalls for load-use.
  - EX requests multi-cycle stalls for madd/msub/div.
- Owns the multi-cycle EX sequencing counter, so the EX unit only signals start and length.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_cnt.sv | 36 +++
 rtl/pipe_ctrl.sv | 105 ++++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall vector layout,
// stall encodings and multi-cycle FSM state encodings.
package pipe_ctrl_pkg;

    // [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=reserved; 1 = hold
    typedef logic [5:0] stall_bus_t;

    localparam stall_bus_t StallNone = 6'b000000;
    localparam stall_bus_t StallId   = 6'b000111;
    localparam stall_bus_t StallEx   = 6'b001111;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Loadable down-counter of remaining multi-cycle EX cycles, with an
// up-counting step index and a zero flag on the remaining count.
module pipe_ctrl_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_step,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_step;

    // A load marks the start cycle as step 0, so the first held cycle is step 1.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_remaining <= '0;
            r_step      <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_val;
            r_step      <= CNT_W'(1);
        end else if (i_dec) begin
            r_remaining <= r_remaining - CNT_W'(1);
            r_step      <= r_step + CNT_W'(1);
        end
    end

    assign o_step = r_step;
    assign o_zero = (r_remaining == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges ID load-use and EX multi-cycle stall requests
// into one stall vector. Optional flush support under PIPE_CTRL_FLUSH_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id_i,
    input  logic             ex_mc_start_i,
    input  logic [CNT_W-1:0] ex_mc_cycles_i,
    output logic [5:0]       stall_o,
    output logic             mc_busy_o,
    output logic [CNT_W-1:0] mc_step_o,
    output logic             mc_last_o
`ifdef PIPE_CTRL_FLUSH_EN
    ,
    input  logic             flush_req_i,
    output logic             flush_o
`endif
);

    mc_state_e        r_state;
    mc_state_e        w_next;
    logic             w_load;
    logic             w_dec;
    logic             w_clear;
    logic [CNT_W-1:0] w_cnt_step;
    logic             w_cnt_zero;

    pipe_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (ex_mc_cycles_i - CNT_W'(2)),
        .i_dec      (w_dec),
        .i_clear    (w_clear),
        .o_step     (w_cnt_step),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        stall_o   = StallNone;
        mc_busy_o = 1'b0;
        mc_step_o = '0;
        mc_last_o = 1'b0;
        w_load    = 1'b0;
        w_dec     = 1'b0;
        w_clear   = 1'b0;
`ifdef PIPE_CTRL_FLUSH_EN
        flush_o   = 1'b0;
`endif
        if (rst) begin
            // all outputs held at zero while in reset
        end
`ifdef PIPE_CTRL_FLUSH_EN
        else if (flush_req_i) begin
            // Flush aborts any op without raising mc_last_o.
            flush_o   = 1'b1;
            mc_busy_o = (r_state == StBusy);
            mc_step_o = (r_state == StBusy) ? w_cnt_step : '0;
            w_clear   = 1'b1;
            w_next    = StIdle;
        end
`endif
        else begin
            case (r_state)
                StIdle: begin
                    if (ex_mc_start_i && (ex_mc_cycles_i >= CNT_W'(2))) begin
                        stall_o = StallEx;
                        w_load  = 1'b1;
                        w_next  = StBusy;
                    end else if (ex_mc_start_i) begin
                        mc_last_o = 1'b1;
                    end else begin
                        stall_o = stallreq_id_i ? StallId : StallNone;
                    end
                end
                StBusy: begin
                    // EX keeps start asserted while held, so inputs are ignored here.
                    mc_busy_o = 1'b1;
                    mc_step_o = w_cnt_step;
                    if (!w_cnt_zero) begin
                        stall_o = StallEx;
                        w_dec   = 1'b1;
                    end else begin
                        mc_last_o = 1'b1;
                        stall_o   = stallreq_id_i ? StallId : StallNone;
                        w_clear   = 1'b1;
                        w_next    = StIdle;
                    end
                end
                default: w_next = StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: op-level reference model checked every cycle, plus
// directed sequences with literal expectations.
module tb_pipe_ctrl;

    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             stallreq_id_i;
    logic             ex_mc_start_i;
    logic [CNT_W-1:0] ex_mc_cycles_i;
    logic [5:0]       stall_o;
    logic             mc_busy_o;
    logic [CNT_W-1:0] mc_step_o;
    logic             mc_last_o;
    logic             fl_drv;
`ifdef PIPE_CTRL_FLUSH_EN
    logic             flush_req_i;
    logic             flush_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: m_active means an op of length m_n is in its held/last phase at index m_k.
    bit m_active = 1'b0;
    int m_k      = 0;
    int m_n      = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id_i  (stallreq_id_i),
        .ex_mc_start_i  (ex_mc_start_i),
        .ex_mc_cycles_i (ex_mc_cycles_i),
        .stall_o        (stall_o),
        .mc_busy_o      (mc_busy_o),
        .mc_step_o      (mc_step_o),
        .mc_last_o      (mc_last_o)
`ifdef PIPE_CTRL_FLUSH_EN
        ,
        .flush_req_i    (flush_req_i),
        .flush_o        (flush_o)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: expected outputs from the op-level rules, compared each cycle.
    always @(negedge clk) begin
        logic [5:0] e_stall;
        logic       e_busy, e_last, e_flush, fl;
        int         e_step, n;
        bit         nx_active;
        int         nx_k;
        e_stall = 6'b000000; e_busy = 1'b0; e_last = 1'b0; e_flush = 1'b0;
        e_step = 0; nx_active = 1'b0; nx_k = 0;
        n = int'(ex_mc_cycles_i);
`ifdef PIPE_CTRL_FLUSH_EN
        fl = flush_req_i;
`else
        fl = 1'b0;
`endif
        if (!rst) begin
            if (fl) begin
                e_flush = 1'b1;
                e_busy  = m_active;
                e_step  = m_active ? m_k : 0;
            end else if (!m_active) begin
                if (ex_mc_start_i && n >= 2) begin
                    e_stall = 6'b001111; nx_active = 1'b1; nx_k = 1; m_n = n;
                end else if (ex_mc_start_i) begin
                    e_last = 1'b1;
                end else begin
                    e_stall = stallreq_id_i ? 6'b000111 : 6'b000000;
                end
            end else begin
                e_busy = 1'b1;
                e_step = m_k;
                if (m_k < m_n - 1) begin
                    e_stall = 6'b001111; nx_active = 1'b1; nx_k = m_k + 1;
                end else begin
                    e_last  = 1'b1;
                    e_stall = stallreq_id_i ? 6'b000111 : 6'b000000;
                end
            end
        end
        check("sb_stall", 32'(stall_o), 32'(e_stall));
        check("sb_busy", 32'(mc_busy_o), 32'(e_busy));
        check("sb_step", 32'(mc_step_o), 32'(e_step));
        check("sb_last", 32'(mc_last_o), 32'(e_last));
`ifdef PIPE_CTRL_FLUSH_EN
        check("sb_flush", 32'(flush_o), 32'(e_flush));
`endif
        m_active = nx_active;
        m_k      = nx_k;
    end

    // Drive one cycle of inputs just after the edge, then return at the sampling edge.
    task automatic cyc(input logic r, input logic id, input logic st, input int n);
        @(posedge clk);
        #1;
        rst = r; stallreq_id_i = id; ex_mc_start_i = st; ex_mc_cycles_i = CNT_W'(n);
`ifdef PIPE_CTRL_FLUSH_EN
        flush_req_i = fl_drv;
`endif
        @(negedge clk);
    endtask

    initial begin
        int ex_cnt, max_step;
        rst = 1'b1; stallreq_id_i = 1'b1; ex_mc_start_i = 1'b1; ex_mc_cycles_i = CNT_W'(5);
        fl_drv = 1'b0;
`ifdef PIPE_CTRL_FLUSH_EN
        flush_req_i = 1'b0;
`endif
        // Reset with every request asserted
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 5);
            check("rst_stall", 32'(stall_o), 32'h0);
            check("rst_busy", 32'(mc_busy_o), 32'h0);
        end
        // Load-use, first cycle after release
        cyc(1'b0, 1'b1, 1'b0, 0);
        check("loaduse", 32'(stall_o), 32'h07);
        cyc(1'b0, 1'b0, 1'b0, 0);
        check("loaduse_end", 32'(stall_o), 32'h00);
        // N=4 op
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 4);
            check("n4_step", 32'(mc_step_o), 32'(i));
            check("n4_stall", 32'(stall_o), (i < 3) ? 32'h0f : 32'h00);
            check("n4_last", 32'(mc_last_o), (i == 3) ? 32'h1 : 32'h0);
        end
        cyc(1'b0, 1'b0, 1'b0, 0);
        check("n4_idle", 32'(mc_busy_o), 32'h0);
        // N=3 op with load-use requested throughout
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 3);
            check("prio_stall", 32'(stall_o), (i < 2) ? 32'h0f : 32'h07);
        end
        cyc(1'b0, 1'b0, 1'b0, 0);
        // Degenerate lengths
        cyc(1'b0, 1'b0, 1'b1, 1);
        check("n1_last", 32'(mc_last_o), 32'h1);
        check("n1_stall", 32'(stall_o), 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 0);
        check("n0_last", 32'(mc_last_o), 32'h1);
        check("n0_busy", 32'(mc_busy_o), 32'h0);
        // Back-to-back N=2 ops
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 2);
            check("b2b_stall", 32'(stall_o), (i % 2 == 0) ? 32'h0f : 32'h00);
            check("b2b_last", 32'(mc_last_o), (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        cyc(1'b0, 1'b0, 1'b0, 0);
        // Maximum length op
        ex_cnt = 0; max_step = 0;
        for (int i = 0; i < 63; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 63);
            if (stall_o == 6'b001111) ex_cnt++;
            if (int'(mc_step_o) > max_step) max_step = int'(mc_step_o);
        end
        check("n63_stalls", 32'(ex_cnt), 32'd62);
        check("n63_maxstep", 32'(max_step), 32'd62);
        cyc(1'b0, 1'b0, 1'b0, 0);
        check("n63_idle", 32'(mc_busy_o), 32'h0);
        // Reset in cycle 2 of an N=10 op
        cyc(1'b0, 1'b0, 1'b1, 10);
        cyc(1'b0, 1'b0, 1'b1, 10);
        cyc(1'b1, 1'b0, 1'b1, 10);
        check("midrst_stall", 32'(stall_o), 32'h0);
        check("midrst_busy", 32'(mc_busy_o), 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 0);
        check("midrst_idle", 32'(mc_busy_o), 32'h0);
        check("midrst_step", 32'(mc_step_o), 32'h0);
`ifdef PIPE_CTRL_FLUSH_EN
        // Flush at step 5 of an N=10 op
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 10);
        fl_drv = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 10);
        check("flush_o", 32'(flush_o), 32'h1);
        check("flush_stall", 32'(stall_o), 32'h0);
        check("flush_last", 32'(mc_last_o), 32'h0);
        check("flush_step", 32'(mc_step_o), 32'd5);
        fl_drv = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 0);
        check("flush_idle", 32'(mc_busy_o), 32'h0);
`endif
        // Mixed load-use pulses in idle
        cyc(1'b0, 1'b1, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b0, 0);
        check("mix_loaduse", 32'(stall_o), 32'h07);
        cyc(1'b0, 1'b0, 1'b0, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
